// File: rtl/noc_node_rr.sv
// -----------------------------------------------------------------------------
// noc_node_rr
// Wormhole-switched mesh router node with round-robin output arbitration.
// Each input owns a FIFO of {last, dest, data}. A head flit looks up its output
// in ROUTE_TABLE. An output locks to one input from grant until that input's
// last flit has gone. A misrouted head is dropped, and the rest of its packet
// is drained and discarded.
//
// Ports
//   clk, rst          : single clock; synchronous active-high reset
//   in_data/dest/last : flit fields per input (flattened, port p at slice p)
//   in_send           : per-input flit valid (FIFO write strobe)
//   in_sendok         : per-output downstream permission (registered internally)
//   out_sendok        : per-input permission to upstream (registered)
//   out_data/dest/last: registered output flit per output port
//   out_send          : registered output valid per output port
//   err               : sticky flags, [p] overflow, [NUM_PORTS+p] misroute
// -----------------------------------------------------------------------------
module noc_node_rr #(
  parameter int NUM_PORTS     = 5,
  parameter int DATAWIDTH     = 32,
  parameter int DESTWIDTH     = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int LOW_WATERMARK = 2,
  parameter logic [(2**DESTWIDTH)*$clog2(NUM_PORTS)-1:0] ROUTE_TABLE = '0,
  parameter bit ALLOW_UTURN   = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS*DATAWIDTH-1:0] in_data,
  input  logic [NUM_PORTS*DESTWIDTH-1:0] in_dest,
  input  logic [NUM_PORTS-1:0]           in_last,
  input  logic [NUM_PORTS-1:0]           in_send,
  input  logic [NUM_PORTS-1:0]           in_sendok,
  output logic [NUM_PORTS-1:0]           out_sendok,
  output logic [NUM_PORTS*DATAWIDTH-1:0] out_data,
  output logic [NUM_PORTS*DESTWIDTH-1:0] out_dest,
  output logic [NUM_PORTS-1:0]           out_last,
  output logic [NUM_PORTS-1:0]           out_send,
  output logic [2*NUM_PORTS-1:0]         err
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = 1 + DESTWIDTH + DATAWIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  // First requesting input at or after ptr, ascending with wrap; MSB = found.
  function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] cand,
                                          input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int          idx;
    res = {(PW+1){1'b0}};
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(ptr) + k) % NUM_PORTS;
      if (!res[PW] && cand[idx]) begin
        res = {1'b1, PW'(idx)};
      end
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] idx);
    return (int'(idx) == NUM_PORTS - 1) ? {PW{1'b0}} : idx + PW'(1);
  endfunction

  // Per-input state
  logic [FW-1:0]          r_mem    [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr [NUM_PORTS];
  logic [AW-1:0]          r_rd_ptr [NUM_PORTS];
  logic [CW-1:0]          r_count  [NUM_PORTS];
  logic [NUM_PORTS-1:0]   r_discard;

  // Per-output state
  state_t                 r_state  [NUM_PORTS];
  logic [PW-1:0]          r_owner  [NUM_PORTS];
  logic [PW-1:0]          r_rr_ptr [NUM_PORTS];
  logic [NUM_PORTS-1:0]   r_sendok;

  // Combinational per-input view
  logic [FW-1:0]          w_head     [NUM_PORTS];
  logic [PW-1:0]          w_req_port [NUM_PORTS];
  logic [NUM_PORTS-1:0]   w_nonempty, w_full, w_owned, w_is_head, w_misroute;
  logic [NUM_PORTS-1:0]   w_pop, w_push, w_ovf;

  // Combinational per-output view
  logic [NUM_PORTS-1:0]   w_cand [NUM_PORTS];
  logic [PW:0]            w_pick [NUM_PORTS];
  logic [PW-1:0]          w_src  [NUM_PORTS];
  logic [NUM_PORTS-1:0]   w_active, w_xfer, w_xfer_last;

  // Head decode, ownership and route lookup for every input
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_head[p]     = r_mem[p][r_rd_ptr[p]];
      w_nonempty[p] = (r_count[p] != {CW{1'b0}});
      w_full[p]     = (r_count[p] == CW'(FIFO_DEPTH));
      w_req_port[p] = ROUTE_TABLE[int'(w_head[p][FW-2 -: DESTWIDTH]) * PW +: PW];
      w_owned[p]    = 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        w_owned[p] = w_owned[p] | ((r_state[o] == S_LOCKED) && (r_owner[o] == PW'(p)));
      end
      // Body flits of a locked packet are never looked up: only an unowned,
      // non-discarding input presents a head flit.
      w_is_head[p]  = w_nonempty[p] & ~w_owned[p] & ~r_discard[p];
      w_misroute[p] = w_is_head[p] &
                      ((int'(w_req_port[p]) >= NUM_PORTS) |
                       (~ALLOW_UTURN & (w_req_port[p] == PW'(p))));
    end
  end

  // Arbitration and transfer decision for every output
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_cand[o][i] = w_is_head[i] & ~w_misroute[i] & (w_req_port[i] == PW'(o));
      end
      w_pick[o]      = rr_pick(w_cand[o], r_rr_ptr[o]);
      // A fresh winner may move its head flit in the very cycle it is granted.
      w_src[o]       = (r_state[o] == S_LOCKED) ? r_owner[o] : w_pick[o][PW-1:0];
      w_active[o]    = (r_state[o] == S_LOCKED) | w_pick[o][PW];
      w_xfer[o]      = w_active[o] & w_nonempty[w_src[o]] & r_sendok[o];
      w_xfer_last[o] = w_xfer[o] & w_head[w_src[o]][FW-1];
    end
  end

  // FIFO pop/push/overflow per input
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_pop[p] = w_nonempty[p] & (r_discard[p] | w_misroute[p]);
      for (int o = 0; o < NUM_PORTS; o++) begin
        w_pop[p] = w_pop[p] | (w_xfer[o] & (w_src[o] == PW'(p)));
      end
      // A full FIFO that is popping this cycle still has room for the push.
      w_push[p] = in_send[p] & (~w_full[p] | w_pop[p]);
      w_ovf[p]  = in_send[p] & w_full[p] & ~w_pop[p];
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset is needed
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_push[p]) begin
        r_mem[p][r_wr_ptr[p]] <= {in_last[p],
                                  in_dest[p*DESTWIDTH +: DESTWIDTH],
                                  in_data[p*DATAWIDTH +: DATAWIDTH]};
      end
    end
  end

  // Input-side control: pointers, occupancy, discard mode, error flags, sendok
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_wr_ptr[p] <= {AW{1'b0}};
        r_rd_ptr[p] <= {AW{1'b0}};
        r_count[p]  <= {CW{1'b0}};
      end
      r_discard  <= {NUM_PORTS{1'b0}};
      err        <= {(2*NUM_PORTS){1'b0}};
      out_sendok <= {NUM_PORTS{1'b0}};
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_push[p]) begin
          r_wr_ptr[p] <= r_wr_ptr[p] + AW'(1);
        end
        if (w_pop[p]) begin
          r_rd_ptr[p] <= r_rd_ptr[p] + AW'(1);
        end
        case ({w_push[p], w_pop[p]})
          2'b10:   r_count[p] <= r_count[p] + CW'(1);
          2'b01:   r_count[p] <= r_count[p] - CW'(1);
          default: r_count[p] <= r_count[p];
        endcase
        // A dropped multi-flit head leaves the rest of its packet to be drained.
        if (w_misroute[p] && !w_head[p][FW-1]) begin
          r_discard[p] <= 1'b1;
        end else if (r_discard[p] && w_pop[p] && w_head[p][FW-1]) begin
          r_discard[p] <= 1'b0;
        end
        if (w_ovf[p]) begin
          err[p] <= 1'b1;
        end
        if (w_misroute[p]) begin
          err[NUM_PORTS+p] <= 1'b1;
        end
        out_sendok[p] <= ((CW'(FIFO_DEPTH) - r_count[p]) > CW'(LOW_WATERMARK));
      end
    end
  end

  // Output-side: lock FSM, round-robin pointer, sendok skid and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_state[o]  <= S_IDLE;
        r_owner[o]  <= {PW{1'b0}};
        r_rr_ptr[o] <= {PW{1'b0}};
      end
      r_sendok <= {NUM_PORTS{1'b0}};
      out_send <= {NUM_PORTS{1'b0}};
      out_data <= {(NUM_PORTS*DATAWIDTH){1'b0}};
      out_dest <= {(NUM_PORTS*DESTWIDTH){1'b0}};
      out_last <= {NUM_PORTS{1'b0}};
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_sendok[o] <= in_sendok[o];
        out_send[o] <= w_xfer[o];
        if (w_xfer[o]) begin
          out_data[o*DATAWIDTH +: DATAWIDTH] <= w_head[w_src[o]][DATAWIDTH-1:0];
          out_dest[o*DESTWIDTH +: DESTWIDTH] <= w_head[w_src[o]][FW-2 -: DESTWIDTH];
          out_last[o]                        <= w_head[w_src[o]][FW-1];
        end
        case (r_state[o])
          S_IDLE: begin
            if (w_pick[o][PW]) begin
              r_owner[o] <= w_pick[o][PW-1:0];
              if (w_xfer_last[o]) begin
                // Single-flit packet: grant, move and release together.
                r_state[o]  <= S_IDLE;
                r_rr_ptr[o] <= next_port(w_pick[o][PW-1:0]);
              end else begin
                r_state[o] <= S_LOCKED;
              end
            end
          end
          S_LOCKED: begin
            if (w_xfer_last[o]) begin
              r_state[o]  <= S_IDLE;
              r_rr_ptr[o] <= next_port(r_owner[o]);
            end
          end
          default: r_state[o] <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_noc_node_rr.sv
module tb_noc_node_rr;

  localparam int N   = 5;
  localparam int DW  = 32;
  localparam int DSW = 4;

  // Route table: destination d goes to port d % 8 (so 5..7 are illegal ports).
  function automatic logic [47:0] mk_rt();
    logic [47:0] r;
    r = '0;
    for (int d = 0; d < 16; d++) r[d*3 +: 3] = 3'(d % 8);
    return r;
  endfunction
  localparam logic [47:0] RT = mk_rt();

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   in_data;
  logic [N*DSW-1:0]  in_dest;
  logic [N-1:0]      in_last, in_send, in_sendok;
  logic [N-1:0]      out_sendok;
  logic [N*DW-1:0]   out_data;
  logic [N*DSW-1:0]  out_dest;
  logic [N-1:0]      out_last, out_send;
  logic [2*N-1:0]    err;

  noc_node_rr #(
    .NUM_PORTS(N), .DATAWIDTH(DW), .DESTWIDTH(DSW), .FIFO_DEPTH(8),
    .LOW_WATERMARK(2), .ROUTE_TABLE(RT), .ALLOW_UTURN(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .in_send(in_send), .in_sendok(in_sendok),
    .out_sendok(out_sendok), .out_data(out_data), .out_dest(out_dest),
    .out_last(out_last), .out_send(out_send), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]     port;
    logic           last;
    logic [DSW-1:0] dest;
    logic [DW-1:0]  data;
  } flit_t;

  flit_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [DSW-1:0] d, input logic [DW-1:0] data,
                       input logic last);
    in_send[p]             = 1'b1;
    in_dest[p*DSW +: DSW]  = d;
    in_data[p*DW +: DW]    = data;
    in_last[p]             = last;
  endtask

  task automatic expect_flit(input int port, input logic [DSW-1:0] d,
                             input logic [DW-1:0] data, input logic last);
    flit_t f;
    f.port = 3'(port);
    f.last = last;
    f.dest = d;
    f.data = data;
    exp_q.push_back(f);
  endtask

  // Wait up to maxw edges for out_send[o]; then measure the contiguous run.
  task automatic watch(input int o, input int maxw, output int dly, output int run);
    dly = -1;
    run = 0;
    for (int i = 1; i <= maxw; i++) begin
      tick();
      if (out_send[o]) begin
        dly = i;
        break;
      end
    end
    if (dly > 0) begin
      run = 1;
      for (int k = 0; k < 64; k++) begin
        tick();
        if (out_send[o]) run++;
        else break;
      end
    end
  endtask

  // Two inputs send n-flit packets to port 0 while it is blocked; pfirst must win.
  task automatic contend(input int pfirst, input int psecond, input int n,
                         input logic [DW-1:0] base, input string tag);
    int dly, run;
    in_sendok[0] = 1'b0;
    tick();
    tick();
    for (int k = 0; k < n; k++) begin
      drive(pfirst,  4'd0, base + DW'(k),          k == n - 1);
      drive(psecond, 4'd0, base + DW'(32'h100 + k), k == n - 1);
      tick();
    end
    in_send = '0;
    for (int k = 0; k < n; k++) expect_flit(0, 4'd0, base + DW'(k), k == n - 1);
    for (int k = 0; k < n; k++) expect_flit(0, 4'd0, base + DW'(32'h100 + k), k == n - 1);
    in_sendok[0] = 1'b1;
    watch(0, 4, dly, run);
    check({tag, "_resume"}, dly, 2);
    check({tag, "_run"}, run, 2 * n);
  endtask

  // Scoreboard monitor: every presented output flit must match the queue head.
  always @(negedge clk) begin
    flit_t e;
    if (rst === 1'b0) begin
      for (int o = 0; o < N; o++) begin
        if (out_send[o] === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_flit: port %0d data %0h, required no flit", o,
                     out_data[o*DW +: DW]);
          end else begin
            e = exp_q.pop_front();
            check("flit", {3'(o), out_last[o], out_dest[o*DSW +: DSW], out_data[o*DW +: DW]},
                  {e.port, e.last, e.dest, e.data});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int dly, run, drops;
    logic act;

    rst = 1'b1; in_send = '0; in_data = '0; in_dest = '0; in_last = '0; in_sendok = '1;
    repeat (3) tick();
    check("rst_out_send", out_send, 0);
    check("rst_err", err, 0);
    check("rst_sendok", out_sendok, 0);
    check("rst_data", out_data[63:0], 0);
    rst = 1'b0;
    check("post_rst_sendok0", out_sendok, 0);
    tick();
    check("post_rst_sendok1", out_sendok, 5'h1F);

    // Single flit, port 1 -> port 3, zero-load latency of 2
    drive(1, 4'd3, 32'hCAFE_0001, 1'b1);
    expect_flit(3, 4'd3, 32'hCAFE_0001, 1'b1);
    tick();
    in_send = '0;
    check("lat_cycle1", out_send, 0);
    tick();
    check("lat_cycle2", out_send, 5'b01000);
    check("single_err", err, 0);

    // Contention rounds on port 0
    contend(1, 2, 4, 32'hA100_0000, "rr_a");   // rr_ptr 0 -> port 1 first, ends at 3
    contend(4, 2, 2, 32'hA200_0000, "rr_b");   // rr_ptr 3 -> port 4 first
    drive(1, 4'd0, 32'hA300_0000, 1'b1);        // single flit moves rr_ptr to 2
    expect_flit(0, 4'd0, 32'hA300_0000, 1'b1);
    tick();
    in_send = '0;
    watch(0, 3, dly, run);
    check("rr_single_dly", dly, 1);
    contend(2, 1, 2, 32'hA400_0000, "rr_c");   // port 2 granted first

    // Backpressure: 8-flit stream from port 1 to port 3
    drops = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, 4'd3, 32'hB000_0000 + DW'(k), k == 7);
      expect_flit(3, 4'd3, 32'hB000_0000 + DW'(k), k == 7);
      tick();
      if (k >= 2 && out_send[3]) drops++;
      if (k == 1) in_sendok[3] = 1'b0;
      if (k == 7) check("bp_sendok_hi", out_sendok[1], 1);
    end
    in_send = '0;
    tick();
    if (out_send[3]) drops++;
    check("bp_sendok_lo", out_sendok[1], 0);
    repeat (3) begin
      tick();
      if (out_send[3]) drops++;
    end
    check("bp_after_drop", drops, 1);
    in_sendok[3] = 1'b1;
    watch(3, 4, dly, run);
    check("bp_resume", dly, 2);
    check("bp_run", run, 6);
    check("bp_err", err, 0);

    // Overflow: 12 writes into a blocked depth-8 FIFO on port 2
    in_sendok[3] = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 12; k++) begin
      drive(2, 4'd3, 32'hD000_0000 + DW'(k), k == 7);
      if (k < 8) expect_flit(3, 4'd3, 32'hD000_0000 + DW'(k), k == 7);
      tick();
    end
    in_send = '0;
    check("ovf_err", err, 10'h004);
    check("ovf_sendok", out_sendok[2], 0);
    in_sendok[3] = 1'b1;
    watch(3, 4, dly, run);
    check("ovf_drain_run", run, 8);
    check("ovf_sticky", err, 10'h004);

    // Misroute: port 2 head targeting itself, 3-flit packet
    act = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2, 4'd2, 32'hE000_0000 + DW'(k), k == 2);
      tick();
      act = act | (|out_send);
    end
    in_send = '0;
    repeat (4) begin
      tick();
      act = act | (|out_send);
    end
    check("mis_quiet", act, 0);
    check("mis_err", err, 10'h084);
    drive(2, 4'd3, 32'hE000_0100, 1'b1);
    expect_flit(3, 4'd3, 32'hE000_0100, 1'b1);
    tick();
    in_send = '0;
    watch(3, 3, dly, run);
    check("mis_next_dly", dly, 1);

    // Misroute to a non-existent port (dest 5 -> port 5)
    act = 1'b0;
    drive(4, 4'd5, 32'hE000_0200, 1'b1);
    tick();
    in_send = '0;
    repeat (3) begin
      tick();
      act = act | (|out_send);
    end
    check("mis_hi_quiet", act, 0);
    check("mis_hi_err", err, 10'h284);

    // Reset mid-packet: 2 of 5 flits buffered behind a blocked output
    in_sendok[3] = 1'b0;
    tick();
    tick();
    drive(1, 4'd3, 32'hF000_0000, 1'b0);
    tick();
    drive(1, 4'd3, 32'hF000_0001, 1'b0);
    tick();
    in_send = '0;
    rst = 1'b1;
    tick();
    check("rrst_send", out_send, 0);
    check("rrst_err", err, 0);
    check("rrst_sendok", out_sendok, 0);
    check("rrst_data", {out_data[127:64], out_data[63:0]}, 0);
    rst = 1'b0;
    in_sendok[3] = 1'b1;
    tick();
    drive(1, 4'd3, 32'hF000_0100, 1'b1);
    expect_flit(3, 4'd3, 32'hF000_0100, 1'b1);
    tick();
    in_send = '0;
    watch(3, 3, dly, run);
    check("rrst_new_dly", dly, 1);
    check("rrst_new_run", run, 1);

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
